hex_entry: RTL and testbench
============================

HEX_ENTRY -- requirements
Module: hex_entry

Interface
REQ-001 The module SHALL have parameter `DEBOUNCE_CYCLES`, default 16: the number of consecutive clocks a synchronized button level must differ from its debounced level before the debounced level flips (legal range 2..65535).
REQ-002 `clk`  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 `reset`  in  1  synchronous, active-high reset.
REQ-004 `digit_in`  in  4  hex digit from the slide switches; asynchronous.
REQ-005 `enter_btn`  in  1  active-high raw button that appends `digit_in` to the edit buffer; asynchronous and bouncy.
REQ-006 `back_btn`  in  1  active-high raw button that deletes the last entered digit; asynchronous and bouncy.
REQ-007 `commit_btn`  in  1  active-high raw button that publishes the edit buffer to `data_*`; asynchronous and bouncy.
REQ-008 `data_0`, `data_1`, `data_2`  out  8 each  committed value; `data_0` is bits [7:0], `data_1` is [15:8], `data_2` is [23:16]; these feed the hex display byte fields.
REQ-009 `edit_0`, `edit_1`, `edit_2`  out  8 each  live edit buffer, using the same byte mapping as `data_*`.
REQ-010 `digit_count`  out  3  number of digits in the edit buffer, range 0..6.
REQ-011 `done`  out  1  one-cycle pulse when a commit takes effect.
REQ-012 `overflow`  out  1  one-cycle pulse when an enter is rejected because the buffer is full.

Function
REQ-013 `enter_btn`, `back_btn`, `commit_btn` and `digit_in` SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce, one independent debouncer per button:
- A counter SHALL increment on each clock where the synchronized level differs from the debounced level.
- The counter SHALL clear on any clock where the two levels are equal.
- The debounced level SHALL flip, and the counter clear, on the clock where the counter would reach `DEBOUNCE_CYCLES`.
REQ-015 A button event SHALL be a single-cycle 0->1 transition of its debounced level; a 1->0 transition SHALL generate no event.
REQ-016 A raw pulse or bounce train shorter than `DEBOUNCE_CYCLES` consecutive stable clocks SHALL produce no event.
REQ-017 Latency: the buffer, `data_*` and pulse outputs SHALL update exactly `DEBOUNCE_CYCLES`+3 rising edges after the first edge that samples the raw button high, given the raw button is stable high throughout.
REQ-018 The edit buffer SHALL be 24 bits; its state SHALL follow `digit_count`: EMPTY (0), PARTIAL (1..5), FULL (6).
REQ-019 Enter event in EMPTY or PARTIAL: buffer <= {buffer[19:0], synchronized `digit_in`}; `digit_count` increments by 1.
REQ-020 Enter event in FULL: buffer and `digit_count` SHALL be unchanged; `overflow` SHALL pulse high for one cycle.
REQ-021 Back event in PARTIAL or FULL: buffer <= {4'h0, buffer[23:4]}; `digit_count` decrements by 1.
REQ-022 Back event in EMPTY SHALL have no effect and SHALL produce no pulse.
REQ-023 Commit event, in any state including EMPTY:
- `data_*` <= buffer.
- Buffer <= 0 and `digit_count` <= 0 on the same edge.
- `done` SHALL pulse high for one cycle.
REQ-024 Simultaneous events in one cycle SHALL be resolved by priority commit > back > enter; lower-priority events in that cycle SHALL be discarded, not queued.
REQ-025 `data_*` SHALL change only on a commit event; `edit_*` and `digit_count` SHALL be registered outputs reflecting the buffer.
REQ-026 `done` and `overflow` SHALL never both be high in the same cycle, and each SHALL be high for exactly one cycle per qualifying event.
REQ-027 Holding a button high indefinitely SHALL produce exactly one event; a further event SHALL require a debounced release followed by a new debounced press.

Reset
REQ-028 While `reset`=1 at a rising edge, the following SHALL be cleared to 0: `data_*`, `edit_*`, `digit_count`, `done`, `overflow`, all synchronizer flops, debounce counters and debounced levels.
REQ-029 Reset asserted mid-debounce or mid-entry SHALL discard all pending and partial state; no event SHALL be generated from samples taken before reset.
REQ-030 A button held high through reset deassertion SHALL generate one event `DEBOUNCE_CYCLES`+3 edges after the first post-reset edge.

Verification (`DEBOUNCE_CYCLES`=4)
REQ-031 Apply reset, then enter digits 1,2,3,4,5,6 each as a clean press, then commit -> `data_2`=0x12, `data_1`=0x34, `data_0`=0x56; `done` high for 1 cycle; `digit_count`=0; `edit_*`=0.
REQ-032 Enter A, B, C, then back, then enter 7 -> `digit_count`=3; `edit_1`=0x0A; `edit_0`=0xB7; `data_*` still 0.
REQ-033 Press enter for 6 digits plus a 7th, with `digit_in`=F -> `overflow` pulses once; the buffer holds the first 6 digits; `digit_count`=6.
REQ-034 Enter pulses of 3 clocks with 3-clock gaps, repeated 10 times, then stable high for 8 clocks -> exactly one enter event, first visible 7 edges after the stable-high sample.
REQ-035 Raise `commit_btn` and `enter_btn` on the same edge with the buffer holding 0x000012 -> `data_0`=0x12; buffer=0; the enter is discarded; `digit_count`=0.
REQ-036 Assert reset 2 clocks into a debounce of `enter_btn`, then release `enter_btn` -> all outputs 0 and no event after reset.

Source files
------------

// File: rtl/hex_entry.sv
// Debounced three-button hex digit entry: shift digits into a 24-bit edit
// buffer, delete the last one, and commit the buffer to the display value.

module hex_entry_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o
);

  localparam logic [15:0] LIMIT = 16'(DEBOUNCE_CYCLES);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        level_prev_q;
  logic [15:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q + 16'd1 == LIMIT) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others (the synchronizer chain
  // depends on this).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  // Only a debounced press counts; a release is silent.
  assign rise_o = level_q & ~level_prev_q;

endmodule

module hex_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       enter_btn,
  input  logic       back_btn,
  input  logic       commit_btn,
  output logic [7:0] data_0,
  output logic [7:0] data_1,
  output logic [7:0] data_2,
  output logic [7:0] edit_0,
  output logic [7:0] edit_1,
  output logic [7:0] edit_2,
  output logic [2:0] digit_count,
  output logic       done,
  output logic       overflow
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fill_e;

  logic [3:0]  digit_s1_q, digit_s2_q;
  logic        enter_ev, back_ev, commit_ev;

  fill_e       state_q, state_d;
  logic [23:0] edit_q, edit_d;
  logic [23:0] data_q, data_d;
  logic [2:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (enter_btn),
    .rise_o (enter_ev)
  );

  hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (back_btn),
    .rise_o (back_ev)
  );

  hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_db (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (commit_btn),
    .rise_o (commit_ev)
  );

  // Commit beats back beats enter; losers in the same cycle are dropped.
  always_comb begin
    edit_d  = edit_q;
    data_d  = data_q;
    count_d = count_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    if (commit_ev) begin
      data_d  = edit_q;
      edit_d  = '0;
      count_d = '0;
      done_d  = 1'b1;
    end else if (back_ev) begin
      if (state_q != EMPTY) begin
        edit_d  = {4'h0, edit_q[23:4]};
        count_d = count_q - 3'd1;
      end
    end else if (enter_ev) begin
      if (state_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        edit_d  = {edit_q[19:0], digit_s2_q};
        count_d = count_q + 3'd1;
      end
    end

    if (count_d == 3'd0) begin
      state_d = EMPTY;
    end else if (count_d == 3'd6) begin
      state_d = FULL;
    end else begin
      state_d = PARTIAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_s1_q <= '0;
      digit_s2_q <= '0;
      state_q    <= EMPTY;
      edit_q     <= '0;
      data_q     <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      digit_s1_q <= digit_in;
      digit_s2_q <= digit_s1_q;
      state_q    <= state_d;
      edit_q     <= edit_d;
      data_q     <= data_d;
      count_q    <= count_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_0      = data_q[7:0];
  assign data_1      = data_q[15:8];
  assign data_2      = data_q[23:16];
  assign edit_0      = edit_q[7:0];
  assign edit_1      = edit_q[15:8];
  assign edit_2      = edit_q[23:16];
  assign digit_count = count_q;
  assign done        = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_hex_entry.sv
// Scoreboard bench for hex_entry with DEBOUNCE_CYCLES=4: each press pushes
// the expected outcome, which is popped when the update is due.

module tb_hex_entry;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       enter_btn, back_btn, commit_btn;
  logic [7:0] data_0, data_1, data_2, edit_0, edit_1, edit_2;
  logic [2:0] digit_count;
  logic       done, overflow;

  hex_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .enter_btn   (enter_btn),
    .back_btn    (back_btn),
    .commit_btn  (commit_btn),
    .data_0      (data_0),
    .data_1      (data_1),
    .data_2      (data_2),
    .edit_0      (edit_0),
    .edit_1      (edit_1),
    .edit_2      (edit_2),
    .digit_count (digit_count),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] edit;
    logic [23:0] data;
    logic [2:0]  cnt;
    logic        done;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] m_edit, m_data;
  logic [2:0]  m_cnt;
  logic [2:0]  prev_cnt;
  int          checks = 0;
  int          failures = 0;

  wire [23:0] edit_w = {edit_2, edit_1, edit_0};
  wire [23:0] data_w = {data_2, data_1, data_0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_edit = '0;
    m_data = '0;
    m_cnt  = '0;
    sb_q.delete();
  endtask

  // Reference behaviour of one event cycle; result goes to the scoreboard.
  task automatic model_step(input logic c, input logic b, input logic e, input logic [3:0] d);
    exp_t x;
    prev_cnt = m_cnt;
    x.done = 1'b0;
    x.ovf  = 1'b0;
    if (c) begin
      m_data = m_edit;
      m_edit = '0;
      m_cnt  = '0;
      x.done = 1'b1;
    end else if (b) begin
      if (m_cnt != 0) begin
        m_edit = m_edit >> 4;
        m_cnt  = m_cnt - 3'd1;
      end
    end else if (e) begin
      if (m_cnt == 3'd6) begin
        x.ovf = 1'b1;
      end else begin
        m_edit = {m_edit[19:0], d};
        m_cnt  = m_cnt + 3'd1;
      end
    end
    x.edit = m_edit;
    x.data = m_data;
    x.cnt  = m_cnt;
    sb_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enter_btn = 1'b0; back_btn = 1'b0; commit_btn = 1'b0; digit_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_edit",  32'(edit_w), 32'd0);
    check("rst_data",  32'(data_w), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // The first posedge after the stimulus is the sampling edge; the update
  // lands on edge D+3 counting that one.
  task automatic expect_update(input string tag);
    exp_t x;
    repeat (D + 2) @(posedge clk);
    #1;
    check({tag, "_early_cnt"}, 32'(digit_count), 32'(prev_cnt));
    check({tag, "_early_pulse"}, 32'({done, overflow}), 32'd0);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check({tag, "_cnt"},  32'(digit_count), 32'(x.cnt));
      check({tag, "_edit"}, 32'(edit_w), 32'(x.edit));
      check({tag, "_data"}, 32'(data_w), 32'(x.data));
      check({tag, "_done"}, 32'(done), 32'(x.done));
      check({tag, "_ovf"},  32'(overflow), 32'(x.ovf));
    end
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, 32'({done, overflow}), 32'd0);
  endtask

  task automatic press(input string tag, input logic c, input logic b, input logic e,
                       input logic [3:0] d);
    @(negedge clk);
    digit_in = d; commit_btn = c; back_btn = b; enter_btn = e;
    model_step(c, b, e, d);
    expect_update(tag);
    @(negedge clk);
    commit_btn = 1'b0; back_btn = 1'b0; enter_btn = 1'b0;
    repeat (D + 4) @(posedge clk);
    #1;
    check({tag, "_release_quiet"}, 32'(digit_count), 32'(m_cnt));
  endtask

  initial begin
    reset = 1'b1;
    digit_in = 4'h0; enter_btn = 1'b0; back_btn = 1'b0; commit_btn = 1'b0;

    do_reset();
    for (int i = 1; i <= 6; i++) press("ent", 1'b0, 1'b0, 1'b1, 4'(i));
    press("commit", 1'b1, 1'b0, 1'b0, 4'h0);
    check("commit_data", 32'(data_w), 32'h123456);

    do_reset();
    press("entA", 1'b0, 1'b0, 1'b1, 4'hA);
    press("entB", 1'b0, 1'b0, 1'b1, 4'hB);
    press("entC", 1'b0, 1'b0, 1'b1, 4'hC);
    press("back", 1'b0, 1'b1, 1'b0, 4'h0);
    press("ent7", 1'b0, 1'b0, 1'b1, 4'h7);
    check("abc_edit", 32'(edit_w), 32'h000AB7);
    check("abc_data", 32'(data_w), 32'h0);

    do_reset();
    for (int i = 1; i <= 6; i++) press("fill", 1'b0, 1'b0, 1'b1, 4'(i));
    press("ovf", 1'b0, 1'b0, 1'b1, 4'hF);
    check("ovf_edit", 32'(edit_w), 32'h123456);
    press("back_full", 1'b0, 1'b1, 1'b0, 4'h0);
    check("back_full_edit", 32'(edit_w), 32'h012345);

    do_reset();
    press("e1", 1'b0, 1'b0, 1'b1, 4'h1);
    press("e2", 1'b0, 1'b0, 1'b1, 4'h2);
    press("commit_enter", 1'b1, 1'b0, 1'b1, 4'h3);
    check("ce_data", 32'(data_w), 32'h000012);
    check("ce_edit", 32'(edit_w), 32'h0);
    press("back_empty", 1'b0, 1'b1, 1'b0, 4'h0);
    press("commit_empty", 1'b1, 1'b0, 1'b0, 4'h0);
    press("e5", 1'b0, 1'b0, 1'b1, 4'h5);
    press("back_enter", 1'b0, 1'b1, 1'b1, 4'h6);

    // Bounce train: ten 3-clock pulses never reach the debounce threshold.
    do_reset();
    digit_in = 4'h7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); enter_btn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); enter_btn = 1'b0;
      repeat (3) @(posedge clk);
    end
    #1;
    check("bounce_none", 32'(digit_count), 32'd0);
    @(negedge clk);
    enter_btn = 1'b1;
    model_step(1'b0, 1'b0, 1'b1, 4'h7);
    expect_update("stable");
    repeat (20) @(posedge clk);
    #1;
    check("hold_one_event", 32'(digit_count), 32'd1);
    check("hold_edit", 32'(edit_w), 32'h7);
    @(negedge clk);
    enter_btn = 1'b0;
    repeat (D + 4) @(posedge clk);

    // Reset two clocks into a debounce discards it.
    do_reset();
    @(negedge clk);
    digit_in = 4'h5; enter_btn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enter_btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("midrst_cnt", 32'(digit_count), 32'd0);
      check("midrst_pulse", 32'({done, overflow}), 32'd0);
    end

    // Button held through reset deassertion yields one event.
    @(negedge clk);
    digit_in = 4'h9; enter_btn = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    model_step(1'b0, 1'b0, 1'b1, 4'h9);
    expect_update("held_rst");
    check("held_rst_edit", 32'(edit_w), 32'h9);
    @(negedge clk);
    enter_btn = 1'b0;
    repeat (D + 4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
